// File: rtl/if_id_stage.sv
// Fetch front end: PC register, IF/ID register, load-use stall and branch flush control.
// Latency: fetched instruction reaches IF/ID one edge later. Backpressure: a load-use hazard freezes PC and IF/ID.
module if_id_stage #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      instr_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_RDaddr_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      branch_target_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      IFID_pc_o,
    output logic [31:0]      IFID_instr_o,
    output logic             stall_o,
    output logic             noop_o,
    output logic             flush_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_t;

    ifid_t             ifid_q;
    logic [31:0]       pc_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic              hazard;
    logic              flush;

    assign rs1 = ifid_q.instr[19:15];
    assign rs2 = ifid_q.instr[24:20];

    // Writes to x0 never create a dependency, so rd == 0 cannot stall.
    assign hazard = IDEX_MemRead_i && (IDEX_RDaddr_i != 5'd0) &&
                    ((IDEX_RDaddr_i == rs1) || (IDEX_RDaddr_i == rs2));

    // A stalled branch resolves on stale operands, so the stall wins.
    assign flush = branch_taken_i && !hazard;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q         <= PC_RESET;
            ifid_q.pc    <= 32'd0;
            ifid_q.instr <= NOP_INSTR;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else if (start_i) begin
            if (hazard) begin
                if (stall_cnt_q != {CNT_W{1'b1}})
                    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end else if (flush) begin
                pc_q         <= branch_target_i;
                ifid_q.pc    <= pc_q;
                ifid_q.instr <= NOP_INSTR;
                if (flush_cnt_q != {CNT_W{1'b1}})
                    flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end else begin
                pc_q         <= pc_q + 32'd4;
                ifid_q.pc    <= pc_q;
                ifid_q.instr <= instr_i;
            end
        end
    end

    assign pc_o         = pc_q;
    assign IFID_pc_o    = ifid_q.pc;
    assign IFID_instr_o = ifid_q.instr;
    assign stall_o      = hazard;
    assign noop_o       = hazard;
    assign flush_o      = flush;
    assign stall_cnt_o  = stall_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: reset, fetch, load-use stall, flush, hold, wrap and counter saturation.
module tb_if_id_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] instr_i;
    logic        IDEX_MemRead_i;
    logic [4:0]  IDEX_RDaddr_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic [31:0] pc_o;
    logic [31:0] IFID_pc_o;
    logic [31:0] IFID_instr_o;
    logic        stall_o;
    logic        noop_o;
    logic        flush_o;
    logic [15:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ADDI_X1 = 32'h00A0_0093;
    localparam logic [31:0] USE_X5  = 32'h0002_8113;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    if_id_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .instr_i(instr_i),
        .IDEX_MemRead_i(IDEX_MemRead_i), .IDEX_RDaddr_i(IDEX_RDaddr_i),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .pc_o(pc_o), .IFID_pc_o(IFID_pc_o), .IFID_instr_o(IFID_instr_o),
        .stall_o(stall_o), .noop_o(noop_o), .flush_o(flush_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc, input logic [31:0] ipc,
                             input logic [31:0] ins, input logic [15:0] sc, input logic [15:0] fc);
        chk({tag, "_pc"}, pc_o, pc);
        chk({tag, "_ifid_pc"}, IFID_pc_o, ipc);
        chk({tag, "_ifid_instr"}, IFID_instr_o, ins);
        chk({tag, "_stall_cnt"}, {16'd0, stall_cnt_o}, {16'd0, sc});
        chk({tag, "_flush_cnt"}, {16'd0, flush_cnt_o}, {16'd0, fc});
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; instr_i = ADDI_X1;
        IDEX_MemRead_i = 1'b0; IDEX_RDaddr_i = 5'd0;
        branch_taken_i = 1'b0; branch_target_i = 32'd0;
        #3;
        chk_state("reset", 32'h0, 32'h0, NOP, 16'd0, 16'd0);
        chk("reset_stall", {31'd0, stall_o}, 32'd0);
        chk("reset_flush", {31'd0, flush_o}, 32'd0);
        #9;
        rst_i = 1'b0; start_i = 1'b1;

        // Sequential fetch
        step();
        chk_state("run1", 32'h4, 32'h0, ADDI_X1, 16'd0, 16'd0);
        instr_i = USE_X5;
        step();
        chk_state("run2", 32'h8, 32'h4, USE_X5, 16'd0, 16'd0);

        // Load-use on rs1 = x5, and the non-hazard variants
        IDEX_MemRead_i = 1'b1; IDEX_RDaddr_i = 5'd0; #1;
        chk("rd0_no_stall", {31'd0, stall_o}, 32'd0);
        IDEX_RDaddr_i = 5'd2; #1;
        chk("rd_mismatch_no_stall", {31'd0, stall_o}, 32'd0);
        IDEX_MemRead_i = 1'b0; IDEX_RDaddr_i = 5'd5; #1;
        chk("no_memread_no_stall", {31'd0, stall_o}, 32'd0);
        IDEX_MemRead_i = 1'b1; #1;
        chk("lu_stall", {31'd0, stall_o}, 32'd1);
        chk("lu_noop", {31'd0, noop_o}, 32'd1);
        step();
        chk_state("lu_hold", 32'h8, 32'h4, USE_X5, 16'd1, 16'd0);
        IDEX_MemRead_i = 1'b0; instr_i = ADDI_X1; #1;
        chk("lu_release", {31'd0, stall_o}, 32'd0);
        step();
        chk_state("lu_resume", 32'hC, 32'h8, ADDI_X1, 16'd1, 16'd0);

        // Taken branch
        branch_taken_i = 1'b1; branch_target_i = 32'h40; #1;
        chk("br_flush", {31'd0, flush_o}, 32'd1);
        step();
        chk_state("br", 32'h40, 32'hC, NOP, 16'd1, 16'd1);
        branch_taken_i = 1'b0; instr_i = USE_X5;
        step();
        chk_state("br_after", 32'h44, 32'h40, USE_X5, 16'd1, 16'd1);

        // Hazard and branch together: stall wins
        IDEX_MemRead_i = 1'b1; IDEX_RDaddr_i = 5'd5;
        branch_taken_i = 1'b1; branch_target_i = 32'h80; #1;
        chk("sim_stall", {31'd0, stall_o}, 32'd1);
        chk("sim_flush", {31'd0, flush_o}, 32'd0);
        step();
        chk_state("sim", 32'h44, 32'h40, USE_X5, 16'd2, 16'd1);
        IDEX_MemRead_i = 1'b0; branch_taken_i = 1'b0;

        // start_i = 0 holds everything
        start_i = 1'b0; instr_i = 32'hDEAD_BEEF;
        repeat (3) step();
        chk_state("hold", 32'h44, 32'h40, USE_X5, 16'd2, 16'd1);

        // PC wrap
        start_i = 1'b1; instr_i = ADDI_X1;
        branch_taken_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
        step();
        chk_state("wrap_br", 32'hFFFF_FFFC, 32'h44, NOP, 16'd2, 16'd2);
        branch_taken_i = 1'b0;
        step();
        chk_state("wrap", 32'h0, 32'hFFFF_FFFC, ADDI_X1, 16'd2, 16'd2);
        step();
        chk("wrap_next_pc", pc_o, 32'h4);

        // Asynchronous reset between edges
        #2 rst_i = 1'b1;
        #1;
        chk_state("async_rst", 32'h0, 32'h0, NOP, 16'd0, 16'd0);
        #2 rst_i = 1'b0;

        // Stall counter saturation
        instr_i = USE_X5;
        step();
        chk_state("sat_setup", 32'h4, 32'h0, USE_X5, 16'd0, 16'd0);
        IDEX_MemRead_i = 1'b1; IDEX_RDaddr_i = 5'd5;
        repeat (65534) step();
        chk("sat_pre", {16'd0, stall_cnt_o}, 32'h0000_FFFE);
        repeat (4) step();
        chk("sat_cnt", {16'd0, stall_cnt_o}, 32'h0000_FFFF);
        chk("sat_pc", pc_o, 32'h4);
        chk("sat_flush_cnt", {16'd0, flush_cnt_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Fetch-side front end of the 5-stage RISC-V pipeline. Holds the PC register and the IF/ID pipeline register, and contains load-use hazard detection and the branch flush logic.
- Feeds the ID stage, and through it the ID/EX register. It tells the ID/EX control path when to insert a bubble.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction (addi x0,x0,0) injected into IF/ID on reset and on flush.
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk_i  in  1  pipeline clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  global run enable; when 0, all state holds.
- instr_i  in  32  instruction memory read data at address pc_o.
- IDEX_MemRead_i  in  1  MemRead control bit currently held in the ID/EX register.
- IDEX_RDaddr_i  in  5  destination register currently held in the ID/EX register.
- branch_taken_i  in  1  branch resolved taken in ID for the instruction in IF/ID.
- branch_target_i  in  32  branch target computed in ID.
- pc_o  out  32  current fetch PC, sent to instruction memory.
- IFID_pc_o  out  32  PC of the instruction held in IF/ID.
- IFID_instr_o  out  32  instruction held in IF/ID.
- stall_o  out  1  load-use hazard present (combinational).
- noop_o  out  1  zero the control bits entering ID/EX this cycle (combinational, equals stall_o).
- flush_o  out  1  effective flush this cycle (combinational).
- stall_cnt_o  out  CNT_W  stall cycles counted.
- flush_cnt_o  out  CNT_W  flushes counted.

Behaviour:
- Field decode from IFID_instr_o: rs1 = [19:15], rs2 = [24:20].
- Hazard condition:
  - hazard = IDEX_MemRead_i AND (IDEX_RDaddr_i != 0) AND (IDEX_RDaddr_i == rs1 OR IDEX_RDaddr_i == rs2).
  - Decoded for every opcode; no opcode qualification.
- Combinational outputs:
  - stall_o = hazard; noop_o = hazard.
  - flush_o = branch_taken_i AND NOT hazard.
  - These outputs do not depend on start_i.
- Priority, stall over branch: a stalled ID instruction has stale operands, so branch_taken_i is ignored while hazard = 1.
- Reset (asynchronous, takes effect immediately, including mid-stall or mid-flush):
  - pc_o = PC_RESET; IFID_instr_o = NOP_INSTR; IFID_pc_o = 0.
  - stall_cnt_o = 0; flush_cnt_o = 0.
- Rising edge with start_i = 0: every register holds its value; counters do not increment.
- Rising edge with start_i = 1, priority order:
  1. hazard = 1: pc_o holds; IFID_pc_o and IFID_instr_o hold; stall_cnt_o increments.
  2. Else flush_o = 1: pc_o <= branch_target_i; IFID_instr_o <= NOP_INSTR; IFID_pc_o <= pc_o; flush_cnt_o increments.
  3. Else: pc_o <= pc_o + 4; IFID_instr_o <= instr_i; IFID_pc_o <= pc_o.
- Latency:
  - Instruction fetched at pc_o appears on IFID_instr_o one cycle later.
  - A taken branch redirects pc_o on the next edge, so the penalty is one bubble.
- Arithmetic:
  - pc_o + 4 is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
  - branch_target_i is used unmodified; alignment is not checked.
- Counters saturate at all-ones; they never wrap.
- Back-to-back stalls: the state holds for as many cycles as hazard stays asserted. In normal operation this is one cycle, since ID/EX receives the bubble.
- After reset, NOP_INSTR decodes rs1 = rs2 = x0, so no spurious hazard is possible.

Test Plan:
- Reset then run: rst_i pulse, start_i = 1, instr_i = 32'h00A00093 -> pc_o = 0, 4, 8 on successive edges; IFID_instr_o = 32'h00A00093 and IFID_pc_o = 0 after the first edge.
- Load-use: IFID_instr_o has rs1 = x5; IDEX_MemRead_i = 1, IDEX_RDaddr_i = 5 -> stall_o = noop_o = 1; pc_o and IF/ID hold one edge; stall_cnt_o = 1. The same stimulus with IDEX_RDaddr_i = 0 gives no stall.
- Branch: branch_taken_i = 1, branch_target_i = 32'h40, pc_o = 8 -> next edge pc_o = 32'h40, IFID_instr_o = 32'h13, IFID_pc_o = 8, flush_cnt_o = 1.
- Simultaneous: hazard plus branch_taken_i in the same cycle -> flush_o = 0; PC holds; stall_cnt_o increments; flush_cnt_o unchanged.
- Hold and wrap:
  - start_i = 0 for 3 edges -> all outputs unchanged.
  - pc_o = 32'hFFFF_FFFC -> next edge pc_o = 0.
  - rst_i asserted between edges -> outputs reset immediately.
- Saturation: force 2^CNT_W + 2 stall cycles -> stall_cnt_o = all-ones.
